// File: rtl/uart_cmd_parser.sv
// Framed command parser behind a UART receiver: HDR0 HDR1 CMD D0..D3 [CHK].
// Define UART_CMD_CHECKSUM_EN to require and verify a trailing checksum byte.
module uart_cmd_parser #(
    parameter logic [7:0] HDR0         = 8'hAB,
    parameter logic [7:0] HDR1         = 8'hBA,
    parameter int         TIMEOUT_CLKS = 8680
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rx_dv,
    input  logic [7:0]  i_rx_byte,
    output logic        o_cmd_dv,
    output logic [7:0]  o_cmd,
    output logic [31:0] o_data,
    output logic        o_chk_err,
    output logic        o_timeout,
    output logic        o_busy
);
    localparam int GW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [GW-1:0] TO_LAST = GW'(TIMEOUT_CLKS - 1);
    localparam logic [GW-1:0] GAP_ONE = {{(GW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_GOT_HDR0,
        S_CMD,
`ifdef UART_CMD_CHECKSUM_EN
        S_CHK,
`endif
        S_DATA
    } state_t;

    state_t        r_state, w_state_nx;
    logic [7:0]    r_cmd_sh, w_cmd_sh_nx;
    logic [31:0]   r_data_sh, w_data_sh_nx;
    logic [1:0]    r_cnt, w_cnt_nx;
    logic [GW-1:0] r_gap;
    logic          r_cmd_dv, r_timeout;
    logic [7:0]    r_cmd;
    logic [31:0]   r_data;
    logic          w_accept, w_timeout;
`ifdef UART_CMD_CHECKSUM_EN
    logic          r_chk_err, w_chk_err;
    logic [7:0]    w_sum;

    assign w_sum = r_cmd_sh + r_data_sh[31:24] + r_data_sh[23:16]
                 + r_data_sh[15:8] + r_data_sh[7:0];
`endif

    always_comb begin
        w_state_nx   = r_state;
        w_cmd_sh_nx  = r_cmd_sh;
        w_data_sh_nx = r_data_sh;
        w_cnt_nx     = r_cnt;
        w_accept     = 1'b0;
        w_timeout    = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
        w_chk_err    = 1'b0;
`endif
        if (i_rx_dv) begin
            case (r_state)
                S_IDLE: begin
                    if (i_rx_byte == HDR0) w_state_nx = S_GOT_HDR0;
                end
                S_GOT_HDR0: begin
                    if (i_rx_byte == HDR1)      w_state_nx = S_CMD;
                    else if (i_rx_byte != HDR0) w_state_nx = S_IDLE;
                end
                S_CMD: begin
                    w_cmd_sh_nx = i_rx_byte;
                    w_cnt_nx    = 2'd0;
                    w_state_nx  = S_DATA;
                end
                S_DATA: begin
                    w_data_sh_nx = {r_data_sh[23:0], i_rx_byte};
                    w_cnt_nx     = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
`ifdef UART_CMD_CHECKSUM_EN
                        w_state_nx = S_CHK;
`else
                        w_state_nx = S_IDLE;
                        w_accept   = 1'b1;
`endif
                    end
                end
`ifdef UART_CMD_CHECKSUM_EN
                S_CHK: begin
                    w_state_nx = S_IDLE;
                    if (i_rx_byte == w_sum) w_accept  = 1'b1;
                    else                    w_chk_err = 1'b1;
                end
`endif
                default: w_state_nx = S_IDLE;
            endcase
        end else if (r_state != S_IDLE && r_gap == TO_LAST) begin
            // A byte arriving in the same cycle wins, hence the else-branch.
            w_state_nx = S_IDLE;
            w_timeout  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cmd_sh  <= 8'd0;
            r_data_sh <= 32'd0;
            r_cnt     <= 2'd0;
            r_gap     <= '0;
            r_cmd_dv  <= 1'b0;
            r_timeout <= 1'b0;
            r_cmd     <= 8'd0;
            r_data    <= 32'd0;
        end else begin
            r_state   <= w_state_nx;
            r_cmd_sh  <= w_cmd_sh_nx;
            r_data_sh <= w_data_sh_nx;
            r_cnt     <= w_cnt_nx;
            r_cmd_dv  <= w_accept;
            r_timeout <= w_timeout;
            if (i_rx_dv || r_state == S_IDLE) r_gap <= '0;
            else                              r_gap <= r_gap + GAP_ONE;
            if (w_accept) begin
                r_cmd  <= w_cmd_sh_nx;
                r_data <= w_data_sh_nx;
            end
        end
    end

`ifdef UART_CMD_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_chk_err <= 1'b0;
        else     r_chk_err <= w_chk_err;
    end
    assign o_chk_err = r_chk_err;
`else
    assign o_chk_err = 1'b0;
`endif

    assign o_cmd_dv  = r_cmd_dv;
    assign o_cmd     = r_cmd;
    assign o_data    = r_data;
    assign o_timeout = r_timeout;
    assign o_busy    = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser; works with or without UART_CMD_CHECKSUM_EN.
module tb_uart_cmd_parser;
  localparam int TO = 8680;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rx_dv;
  logic [7:0]  i_rx_byte;
  logic        o_cmd_dv;
  logic [7:0]  o_cmd;
  logic [31:0] o_data;
  logic        o_chk_err;
  logic        o_timeout;
  logic        o_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_cmd_dv = 0;
  int n_chk_err = 0;
  int n_timeout = 0;
  int n_multi = 0;

  logic [39:0] exp_q[$];

  uart_cmd_parser #(.HDR0(8'hAB), .HDR1(8'hBA), .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .rst(rst), .i_rx_dv(i_rx_dv), .i_rx_byte(i_rx_byte),
    .o_cmd_dv(o_cmd_dv), .o_cmd(o_cmd), .o_data(o_data),
    .o_chk_err(o_chk_err), .o_timeout(o_timeout), .o_busy(o_busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every o_cmd_dv must match the next expected {cmd,data}
  always @(negedge clk) begin
    if (!rst) begin
      if (o_cmd_dv) n_cmd_dv++;
      if (o_chk_err) n_chk_err++;
      if (o_timeout) n_timeout++;
      if ((o_cmd_dv + o_chk_err + o_timeout) > 1) n_multi++;
      if (o_cmd_dv) begin
        if (exp_q.size() == 0) check("unexpected_cmd_dv", {o_cmd, o_data}, 40'h0);
        else check("scoreboard", {o_cmd, o_data}, exp_q.pop_front());
      end
    end
  end

  // driver
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    i_rx_dv = 1'b1;
    i_rx_byte = b;
    @(negedge clk);
    i_rx_dv = 1'b0;
    i_rx_byte = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame_body(input logic [7:0] cmd, input logic [31:0] data);
    send_byte(8'hAB);
    send_byte(8'hBA);
    send_byte(cmd);
    send_byte(data[31:24]);
    send_byte(data[23:16]);
    send_byte(data[15:8]);
    send_byte(data[7:0]);
  endtask

  task automatic send_good(input logic [7:0] cmd, input logic [31:0] data);
    exp_q.push_back({cmd, data});
    send_frame_body(cmd, data);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(cmd + data[31:24] + data[23:16] + data[15:8] + data[7:0]);
`endif
    check("good_frame_dv", {39'd0, o_cmd_dv}, 40'd1);
    @(negedge clk);
    check("good_frame_dv_one_cycle", {39'd0, o_cmd_dv}, 40'd0);
    check("good_frame_out", {o_cmd, o_data}, {cmd, data});
    idle(2);
  endtask

  initial begin : main
    int cnt;
    int c0, e0, t0;
    rst = 1'b1;
    i_rx_dv = 1'b0;
    i_rx_byte = 8'h00;
    idle(3);
    check("reset_outputs", {o_cmd_dv, o_chk_err, o_timeout, o_busy, o_cmd, o_data[27:0]}, 40'h0);
    check("reset_data", {8'h0, o_data}, 40'h0);
    rst = 1'b0;
    idle(2);

    // basic valid frame (1 cycle latency checked inside send_good)
    send_good(8'h01, 32'h12345678);
    send_good(8'hFF, 32'hFFFFFFFF);

`ifdef UART_CMD_CHECKSUM_EN
    // bad checksum: 01+12+34+56+78 = 0x115 -> 0x15 expected, 0x16 sent
    c0 = n_cmd_dv;
    send_frame_body(8'h01, 32'h12345678);
    send_byte(8'h16);
    check("bad_chk_err", {39'd0, o_chk_err}, 40'd1);
    check("bad_chk_no_dv", {39'd0, o_cmd_dv}, 40'd0);
    idle(2);
    check("bad_chk_hold", {o_cmd, o_data}, {8'hFF, 32'hFFFFFFFF});
    check("bad_chk_dv_count", n_cmd_dv, c0);
`endif

    // resync: stray byte, repeated HDR0
    exp_q.push_back({8'h02, 32'h00000005});
    send_byte(8'h00);
    check("ignore_stray_busy", {39'd0, o_busy}, 40'd0);
    send_byte(8'hAB);
    send_byte(8'hAB);
    check("hdr0_repeat_busy", {39'd0, o_busy}, 40'd1);
    send_byte(8'hBA);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h05);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'h07);
`endif
    check("resync_dv", {39'd0, o_cmd_dv}, 40'd1);
    idle(1);
    check("resync_out", {o_cmd, o_data}, {8'h02, 32'h00000005});
    idle(2);

    // timeout after AB BA 03
    c0 = n_cmd_dv;
    send_byte(8'hAB);
    send_byte(8'hBA);
    send_byte(8'h03);
    cnt = 0;
    while (cnt < TO + 100 && !o_timeout) begin
      @(negedge clk);
      cnt++;
    end
    check("timeout_latency", cnt, TO);
    check("timeout_pulse", {39'd0, o_timeout}, 40'd1);
    check("timeout_busy", {39'd0, o_busy}, 40'd0);
    @(negedge clk);
    check("timeout_one_cycle", {39'd0, o_timeout}, 40'd0);
    check("timeout_hold", {o_cmd, o_data}, {8'h02, 32'h00000005});
    check("timeout_no_dv", n_cmd_dv, c0);
    send_good(8'h0A, 32'hCAFEF00D);

    // reset mid-frame
    c0 = n_cmd_dv; e0 = n_chk_err; t0 = n_timeout;
    send_byte(8'hAB);
    send_byte(8'hBA);
    send_byte(8'h01);
    send_byte(8'h12);
    rst = 1'b1;
    #1;
    check("midrst_busy", {39'd0, o_busy}, 40'd0);
    check("midrst_out", {o_cmd, o_data}, 40'h0);
    idle(2);
    rst = 1'b0;
    idle(3);
    check("midrst_no_strobe", {n_cmd_dv[7:0], n_chk_err[7:0], n_timeout[7:0]},
          {c0[7:0], e0[7:0], t0[7:0]});
    send_good(8'h5A, 32'h00C0FFEE);

    idle(4);
    check("scoreboard_drained", exp_q.size(), 0);
    check("strobes_exclusive", n_multi, 0);
`ifdef UART_CMD_CHECKSUM_EN
    check("chk_err_count", n_chk_err, 1);
`else
    check("chk_err_count", n_chk_err, 0);
`endif
    check("timeout_count", n_timeout, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
